// File: rtl/updi_break_detect.sv
// UPDI break / double-break detector.
// Measures low and high run lengths on the sampled UPDI line. One counter is
// shared by all states. The detector pulses break_det when a low run of at
// least BREAK_CLK samples ends. It pulses double_break_det together with
// break_det when a second such run follows a gap of at most GAP_MAX_CLK high
// samples.
// Optional macro UPDI_BREAK_SYNC_EN: passes rx through a 2-flop synchronizer,
// which adds 2 cycles of latency. The run-length thresholds do not change.
module updi_break_detect #(
    parameter int unsigned BREAK_CLK   = 10,
    parameter int unsigned GAP_MAX_CLK = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rx,
    output logic busy,
    output logic break_det,
    output logic double_break_det
);

    localparam int unsigned MaxClk = (BREAK_CLK > GAP_MAX_CLK) ? BREAK_CLK : GAP_MAX_CLK;
    localparam int unsigned CntW   = $clog2(MaxClk + 2);

    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};
    localparam logic [CntW-1:0] BreakThr = CntW'(BREAK_CLK);
    localparam logic [CntW-1:0] GapThr   = CntW'(GAP_MAX_CLK);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow1 = 2'd1,
        StGap  = 2'd2,
        StLow2 = 2'd3
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [CntW-1:0] w_cnt_inc;
    logic            r_break_det;
    logic            r_double_det;
    logic            w_break_d;
    logic            w_double_d;
    logic            w_s;

`ifdef UPDI_BREAK_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer; preset high so reset release never looks like a low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_s = r_sync[1];
`else
    assign w_s = rx;
`endif

    // Saturating increment of the shared run counter
    assign w_cnt_inc = (r_cnt == CntSat) ? r_cnt : r_cnt + CntOne;

    // State, counter and registered pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_break_det  <= 1'b0;
            r_double_det <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_break_det  <= w_break_d;
            r_double_det <= w_double_d;
        end
    end

    // Next-state, next-count and pulse decisions
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_break_d  = 1'b0;
        w_double_d = 1'b0;

        if (!en) begin
            // Disable wins in every state and suppresses any pending pulse
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!w_s) begin
                        w_state_d = StLow1;
                        w_cnt_d   = CntOne;
                    end
                end
                StLow1: begin
                    if (!w_s) begin
                        w_cnt_d = w_cnt_inc;
                    end else if (r_cnt >= BreakThr) begin
                        // The rising sample is the first high of the gap
                        w_state_d = StGap;
                        w_cnt_d   = CntOne;
                        w_break_d = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end
                end
                StGap: begin
                    if (!w_s) begin
                        w_state_d = StLow2;
                        w_cnt_d   = CntOne;
                    end else if (r_cnt >= GapThr) begin
                        // One high sample past the allowed gap
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                StLow2: begin
                    if (!w_s) begin
                        w_cnt_d = w_cnt_inc;
                    end else begin
                        // A third break always starts a fresh sequence from idle
                        w_state_d  = StIdle;
                        w_cnt_d    = '0;
                        w_break_d  = (r_cnt >= BreakThr);
                        w_double_d = (r_cnt >= BreakThr);
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy             = (r_state != StIdle);
        break_det        = r_break_det;
        double_break_det = r_double_det;
    end

endmodule

// File: tb/tb_updi_break_detect.sv
// Scoreboard bench for updi_break_detect (BREAK_CLK=10, GAP_MAX_CLK=20).
// The stimulus queues each expected pulse and the cycle in which it should
// appear. A monitor pops one entry for every pulse the DUT shows.
module tb_updi_break_detect;

`ifdef UPDI_BREAK_SYNC_EN
    localparam int unsigned Lat = 2;
`else
    localparam int unsigned Lat = 0;
`endif

    typedef struct {
        int unsigned cyc;
        bit          dbl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic rx  = 1'b1;
    logic busy;
    logic break_det;
    logic double_break_det;

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];

    updi_break_detect #(
        .BREAK_CLK  (10),
        .GAP_MAX_CLK(20)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .rx              (rx),
        .busy            (busy),
        .break_det       (break_det),
        .double_break_det(double_break_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hold rx at v for n rising edges, starting and ending on a falling edge
    task automatic drive(input bit v, input int n);
        repeat (n) begin
            rx = v;
            @(negedge clk);
        end
    endtask

    // Call right before driving the high sample that ends a qualifying low run
    task automatic expect_pulse(input bit dbl);
        exp_t e;
        e.cyc = cyc + 1 + Lat;
        e.dbl = dbl;
        q.push_back(e);
    endtask

    // Monitor: every pulse seen must match the next queued expectation
    always @(negedge clk) begin
        if (break_det || double_break_det) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got brk=%0b dbl=%0b at cycle %0d, expected none",
                         break_det, double_break_det, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || !break_det || double_break_det != e.dbl) begin
                    errors++;
                    $display("FAIL pulse: got brk=%0b dbl=%0b at cycle %0d, expected brk=1 dbl=%0b at cycle %0d",
                             break_det, double_break_det, cyc, e.dbl, e.cyc);
                end
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_brk", int'(break_det), 0);
        chk("reset_dbl", int'(double_break_det), 0);
        rst = 1'b0;
        drive(1, 3);

        // Single break of exactly BREAK_CLK lows; busy holds for 20 gap highs
        drive(0, 10);
        expect_pulse(0);
        drive(1, 20 + Lat);
        chk("gap20_busy", int'(busy), 1);
        drive(1, 1);
        chk("gap21_idle", int'(busy), 0);

        // Nine lows: no pulse, busy drops on the edge that samples the high
        drive(0, 9);
        drive(1, Lat);
        chk("short_busy", int'(busy), 1);
        drive(1, 1);
        chk("short_idle", int'(busy), 0);
        drive(1, 5);

        // Double break with a 10-cycle gap
        drive(0, 10);
        expect_pulse(0);
        drive(1, 10);
        drive(0, 10);
        expect_pulse(1);
        drive(1, 25);

        // Longest allowed gap (20 highs) still forms a double break
        drive(0, 10);
        expect_pulse(0);
        drive(1, 20);
        drive(0, 10);
        expect_pulse(1);
        drive(1, 25);

        // Gap of 21 highs: two isolated breaks
        drive(0, 10);
        expect_pulse(0);
        drive(1, 21);
        drive(0, 10);
        expect_pulse(0);
        drive(1, 25);

        // Asynchronous reset mid-break discards the partial run
        drive(0, 5);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 5);
        drive(1, 5 + Lat);
        chk("rst_run_idle", int'(busy), 0);

        // Enable dropped during the gap forces idle, so the next break is single
        drive(0, 10);
        expect_pulse(0);
        drive(1, 5 + Lat);
        chk("gap_busy", int'(busy), 1);
        en = 1'b0;
        drive(1, 1);
        chk("en_off_idle", int'(busy), 0);
        en = 1'b1;
        drive(1, 2);
        drive(0, 10);
        expect_pulse(0);
        drive(1, 25);

        // Very long low run yields exactly one break
        drive(0, 1000);
        expect_pulse(0);
        drive(1, 25);

        // Three breaks back to back: single + double, then a fresh single
        drive(0, 10);
        expect_pulse(0);
        drive(1, 5);
        drive(0, 10);
        expect_pulse(1);
        drive(1, 5);
        drive(0, 10);
        expect_pulse(0);
        drive(1, 25);

        // Second low too short: only the first break
        drive(0, 10);
        expect_pulse(0);
        drive(1, 5);
        drive(0, 9);
        drive(1, 25);

        drive(1, 10);
        chk("pending_pulses", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updi_break_detect.md
UPDI_BREAK_DETECT -- requirements
Module: updi_break_detect

Interface
REQ-001 SHALL have parameter BREAK_CLK, default 10: minimum consecutive low samples that qualify as a break.
REQ-002 SHALL have parameter GAP_MAX_CLK, default 20: maximum consecutive high samples between two breaks that still form a double break.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  in  1  detection enable.
REQ-006 SHALL have port rx  in  1  UPDI line, idle high.
REQ-007 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-008 SHALL have port break_det  out  1  one-cycle pulse per qualifying break.
REQ-009 SHALL have port double_break_det  out  1  one-cycle pulse per qualifying double break.

Function
REQ-010 SHALL drive the FSM from sampled line s, where s is rx or its synchronized copy (see Configuration).
REQ-011 SHALL implement states IDLE, LOW1, GAP and LOW2, with a single shared run counter.
REQ-012 SHALL size the counter as clog2(max(BREAK_CLK, GAP_MAX_CLK) + 2) bits and saturate it, never wrap.
REQ-013 IDLE: s=0 and en=1 -> LOW1, cnt=1; otherwise stay in IDLE.
REQ-014 LOW1: s=0 -> cnt+1 (saturating); s=1 with cnt>=BREAK_CLK -> GAP, cnt=1, break_det pulse; s=1 with cnt<BREAK_CLK -> IDLE, no pulse.
REQ-015 GAP: s=1 -> cnt+1; (GAP_MAX_CLK+1)th consecutive high sample -> IDLE; s=0 -> LOW2, cnt=1.
REQ-016 LOW2: s=0 -> cnt+1 (saturating); s=1 with cnt>=BREAK_CLK -> IDLE with break_det and double_break_det pulsed together; s=1 with cnt<BREAK_CLK -> IDLE, no pulse.
REQ-017 SHALL register pulses: high for exactly one cycle after the edge that samples s=1 ending the qualifying low run.
REQ-018 A low run of any length >= BREAK_CLK SHALL produce exactly one break_det.
REQ-019 en=0 in any state SHALL force IDLE at the next edge with no pulses, overriding REQ-013 to REQ-016.
REQ-020 SHALL generate double_break_det only for the LOW1->GAP->LOW2 sequence; a third break starts a new sequence from IDLE.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, cnt=0, busy=0, break_det=0, double_break_det=0, independent of clk.
REQ-022 Reset SHALL preset synchronizer flops to 1 (line idle) so no false low is seen after release.
REQ-023 Reset asserted mid-break SHALL discard the partial run; counting restarts only at a new falling sample after release.

Configuration
REQ-024 Macro UPDI_BREAK_SYNC_EN defined: rx SHALL pass through a 2-flop synchronizer and s is its output, adding 2 cycles of latency to every transition and pulse.
REQ-025 Macro UPDI_BREAK_SYNC_EN undefined: s SHALL equal rx directly, with no added latency; run-length thresholds are identical in both builds.

Verification
REQ-026 With BREAK_CLK=10, GAP_MAX_CLK=20, sync off: rx low 10 cycles then high -> one break_det pulse, no double_break_det, busy=0 after 21 high samples.
REQ-027 rx low 9 cycles then high -> no pulses, busy falls the cycle after rx rises.
REQ-028 rx low 10, high 10, low 10, high -> break_det twice; double_break_det once, coincident with the second break_det.
REQ-029 Gap of 20 high cycles -> double_break_det fires; gap of 21 -> two isolated break_det pulses, no double_break_det.
REQ-030 rst pulsed at low cycle 5, then low 5 more -> no pulses; en dropped during GAP -> IDLE, no double_break_det.
REQ-031 Sync on, stimulus of REQ-028 -> identical pulses delayed by exactly 2 cycles; rx low 1000 cycles -> exactly one break_det.
